// File: rtl/fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit_if : instruction-memory handshake and decoder-side output bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_ack, imem_rdata, stall
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_ack, imem_rdata, stall
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : PC owner, imem req/ack fetch, one-entry output slot + skid buf
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_disc_addr;
  logic [31:0] r_buf;
  logic [31:0] r_buf_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;

  logic        w_slot_free;
  logic [31:0] w_target;

  assign w_slot_free = !r_inst_valid || !bus.stall;
  assign w_target    = branch_target & c_align_mask;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC & c_align_mask;
      r_disc_addr  <= 32'h0;
      r_buf        <= 32'h0;
      r_buf_pc     <= 32'h0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= 32'h0;
      r_inst_valid <= 1'b0;
    end else if (branch_taken) begin
      // Redirect flushes the slot and buffer regardless of stall or ack.
      r_pc         <= w_target;
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (!bus.imem_ack) begin
            r_state     <= ST_DISCARD;
            r_disc_addr <= r_pc;
          end
        end
        ST_HOLD:    r_state <= ST_FETCH;
        ST_DISCARD: if (bus.imem_ack) r_state <= ST_FETCH;
        default:    r_state <= ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.imem_ack) begin
            r_pc <= r_pc + 32'd4;
            if (w_slot_free) begin
              r_inst       <= bus.imem_rdata;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
            end else begin
              r_buf    <= bus.imem_rdata;
              r_buf_pc <= r_pc;
              r_state  <= ST_HOLD;
            end
          end else if (r_inst_valid && !bus.stall) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (w_slot_free) begin
            r_inst       <= r_buf;
            r_inst_pc    <= r_buf_pc;
            r_inst_valid <= 1'b1;
            r_state      <= ST_FETCH;
          end
        end
        ST_DISCARD: begin
          // Wrong-path word completes the old transaction and is dropped.
          if (bus.imem_ack) r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Request drops with reset asserted so an in-flight fetch is abandoned at once.
  assign bus.imem_req   = nrst && (r_state != ST_HOLD);
  assign bus.imem_addr  = (r_state == ST_DISCARD) ? r_disc_addr : r_pc;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.inst_valid = r_inst_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed scenarios plus randomized run against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        nrst;
  logic        branch_taken;
  logic [31:0] branch_target;
  int          n_vec;
  int          n_err;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .nrst(nrst), .branch_taken(branch_taken),
    .branch_target(branch_target), .bus(bus.master)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut2 (
    .clk(clk), .nrst(nrst), .branch_taken(1'b0),
    .branch_target(32'h0), .bus(bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of delivered-but-unconsumed words {data, pc};
  // front is what the decoder sees, a second entry means the buffer is full.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic [31:0] m_daddr;
  logic        m_discard;

  function automatic logic m_req();
    return m_discard || (q.size() < 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc      = 32'h0;
    m_daddr   = 32'h0;
    m_discard = 1'b0;
  endtask

  task automatic model_update(input logic s, input logic b, input logic [31:0] t,
                              input logic a, input logic [31:0] d);
    logic req, consumed;
    req      = m_req();
    consumed = (q.size() > 0) && !s;
    if (b) begin
      if (m_discard) begin
        if (a) m_discard = 1'b0;
      end else if (req && !a) begin
        m_discard = 1'b1;
        m_daddr   = m_pc;
      end
      m_pc = {t[31:2], 2'b00};
      q.delete();
    end else if (m_discard) begin
      if (a) m_discard = 1'b0;
    end else begin
      if (consumed) void'(q.pop_front());
      if (a && req) begin
        q.push_back({d, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Drive one cycle at the negedge, advance the model at the posedge,
  // return at the following negedge for sampling.
  task automatic step(input logic s, input logic b, input logic [31:0] t,
                      input logic a, input logic [31:0] d);
    bus.stall      = s;
    branch_taken   = b;
    branch_target  = t;
    bus.imem_ack   = a;
    bus.imem_rdata = d;
    @(posedge clk);
    if (nrst) model_update(s, b, t, a, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    bus2.stall = 1'b0; bus2.imem_ack = 1'b0; bus2.imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst !== NOP || bus.inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset: req=%b valid=%b inst=%h pc=%h, want 0 0 %h 0",
               bus.imem_req, bus.inst_valid, bus.inst, bus.inst_pc, NOP);
    end
    nrst = 1'b1;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release: req=%b addr=%h, want 1 00000000", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] w[3];
    w[0] = 32'h0010_0093; w[1] = 32'h0020_0113; w[2] = 32'h0030_0193;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL stream_addr[%0d]: req=%b addr=%h, want 1 %h", k, bus.imem_req, bus.imem_addr, 32'(4 * k));
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, w[k]);
      n_vec++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== w[k] || bus.inst_pc !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL stream_out[%0d]: valid=%b inst=%h pc=%h, want 1 %h %h",
                 k, bus.inst_valid, bus.inst, bus.inst_pc, w[k], 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall_hold();
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0213);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus.imem_req !== 1'b0 || bus.inst !== 32'h0030_0193 || bus.inst_pc !== 32'h8 || bus.inst_valid !== 1'b1) begin
        n_err++;
        $display("FAIL hold[%0d]: req=%b inst=%h pc=%h valid=%b, want 0 00300193 00000008 1",
                 k, bus.imem_req, bus.inst, bus.inst_pc, bus.inst_valid);
      end
      if (k < 2) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (bus.inst !== 32'h0040_0213 || bus.inst_pc !== 32'hC || bus.inst_valid !== 1'b1 ||
        bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL hold_release: inst=%h pc=%h valid=%b req=%b addr=%h, want 00400213 0000000c 1 1 00000010",
               bus.inst, bus.inst_pc, bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0293);
    n_vec++;
    if (bus.inst !== 32'h0050_0293 || bus.inst_pc !== 32'h10 || bus.inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_resume: inst=%h pc=%h valid=%b, want 00500293 00000010 1",
               bus.inst, bus.inst_pc, bus.inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    n_vec++;
    if (bus.inst_valid !== 1'b0 || bus.inst !== NOP || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin
      n_err++;
      $display("FAIL redirect_flush: valid=%b inst=%h req=%b addr=%h, want 0 %h 1 00000014",
               bus.inst_valid, bus.inst, bus.imem_req, bus.imem_addr, NOP);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin
      n_err++;
      $display("FAIL discard_hold: req=%b addr=%h, want 1 00000014", bus.imem_req, bus.imem_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    n_vec++;
    if (bus.inst_valid !== 1'b0 || bus.inst !== NOP || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL discard_drop: valid=%b inst=%h req=%b addr=%h, want 0 %h 1 00000100",
               bus.inst_valid, bus.inst, bus.imem_req, bus.imem_addr, NOP);
    end
  endtask

  task automatic test_redirect_priority();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0060_0313);
    step(1'b1, 1'b1, 32'h0000_0203, 1'b1, 32'hBAD0_BAD0);
    n_vec++;
    if (bus.inst_valid !== 1'b0 || bus.inst !== NOP || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL redirect_priority: valid=%b inst=%h req=%b addr=%h, want 0 %h 1 00000200",
               bus.inst_valid, bus.inst, bus.imem_req, bus.imem_addr, NOP);
    end
  endtask

  task automatic test_wrap();
    n_vec++;
    if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_start: req=%b addr=%h, want 1 fffffffc", bus2.imem_req, bus2.imem_addr);
    end
    bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h0070_0393;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    bus2.imem_ack = 1'b0;
    n_vec++;
    if (bus2.imem_addr !== 32'h0 || bus2.inst_pc !== 32'hFFFF_FFFC || bus2.inst !== 32'h0070_0393) begin
      n_err++;
      $display("FAIL wrap: addr=%h pc=%h inst=%h, want 00000000 fffffffc 00700393",
               bus2.imem_addr, bus2.inst_pc, bus2.inst);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0080_0413);
    bus.stall = 1'b1; bus.imem_ack = 1'b0;
    #2 nrst = 1'b0;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.inst !== NOP) begin
      n_err++;
      $display("FAIL async_reset: req=%b valid=%b inst=%h, want 0 0 %h", bus.imem_req, bus.inst_valid, bus.inst, NOP);
    end
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    #1;
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL async_restart: req=%b addr=%h, want 1 00000000", bus.imem_req, bus.imem_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0090_0493);
    n_vec++;
    if (bus.inst_pc !== 32'h0 || bus.inst !== 32'h0090_0493 || bus.inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL async_first: pc=%h inst=%h valid=%b, want 00000000 00900493 1",
               bus.inst_pc, bus.inst, bus.inst_valid);
    end
  endtask

  task automatic test_random();
    logic        s, b, a;
    logic [31:0] t, d, e_inst, e_addr;
    logic        e_valid, e_req;
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom % 4) == 0;
      b = ($urandom % 16) == 0;
      t = $urandom;
      a = m_req() && (($urandom % 3) != 0);
      d = $urandom;
      step(s, b, t, a, d);
      e_valid = q.size() > 0;
      e_inst  = e_valid ? q[0][63:32] : NOP;
      e_req   = m_req();
      e_addr  = m_discard ? m_daddr : m_pc;
      n_vec++;
      if (bus.inst_valid !== e_valid || bus.inst !== e_inst || (e_valid && bus.inst_pc !== q[0][31:0]) ||
          bus.imem_req !== e_req || (e_req && bus.imem_addr !== e_addr)) begin
        n_err++;
        $display("FAIL random[%0d]: valid=%b inst=%h pc=%h req=%b addr=%h, want %b %h %h %b %h",
                 n, bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req, bus.imem_addr,
                 e_valid, e_inst, e_valid ? q[0][31:0] : bus.inst_pc, e_req, e_addr);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_priority();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
